// File: rtl/port_serial_tx.sv
// Port-bus peripheral that serialises firmware-queued bytes onto a UART-style line.
// A one-entry holding buffer lets firmware queue the next byte while a frame is in flight.
module port_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] port_data_i,
    input  logic [7:0] port_ctrl_i,
    output logic [7:0] port_status_o,
    output logic       tx_o
);

    localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              req_seen_q, req_seen_d;
    logic              ovr_q, ovr_d;
    logic              done_q, done_d;
    logic [3:0]        count_q, count_d;
    logic              busy_q, busy_d;
    logic              tx_q, tx_d;

    logic req, bit_end, frame_end, ovr_set;

    logic unused_ctrl;
    assign unused_ctrl = ^port_ctrl_i[6:1];

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovr_d       = ovr_q;
        done_d      = done_q;
        count_d     = count_q;
        ovr_set     = 1'b0;

        req        = port_ctrl_i[0] != req_seen_q;
        req_seen_d = port_ctrl_i[0];
        bit_end    = timer_q == TimerLast;
        frame_end  = (state_q == StStop) && bit_end && (bit_q == LastStop);
        timer_d    = (state_q == StIdle || bit_end) ? '0 : timer_q + 1'b1;

        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    bit_d   = 3'd0;
                end
            end
            StStop: begin
                if (frame_end) begin
                    done_d  = ~done_q;
                    count_d = count_q + 4'd1;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // On a frame-end edge the hold slot is being vacated, so a request can refill it.
        if (req) begin
            if (state_q == StIdle || (frame_end && !hold_full_q)) begin
                shift_d = port_data_i;
                state_d = StStart;
                bit_d   = 3'd0;
            end else if (!hold_full_q || frame_end) begin
                hold_d      = port_data_i;
                hold_full_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        if (port_ctrl_i[7]) ovr_d = 1'b0;
        if (ovr_set) ovr_d = 1'b1;

        busy_d = state_d != StIdle;

        // tx is computed from next state so the line follows the state with no extra lag.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[bit_d];
            StParity: tx_d = ^shift_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            req_seen_q  <= 1'b0;
            ovr_q       <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= 4'd0;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            req_seen_q  <= req_seen_d;
            ovr_q       <= ovr_d;
            done_q      <= done_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            tx_q        <= tx_d;
        end
    end

    assign port_status_o = {count_q, done_q, ovr_q, hold_full_q, busy_q};
    assign tx_o          = tx_q;

endmodule

// File: tb/tb_port_serial_tx.sv
// Directed bench for port_serial_tx: plain 8N1 instance and an 8E2 instance, both 4 clks/bit.
module tb_port_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data = 8'h00, ctrl = 8'h00, status;
    logic [7:0] data_p = 8'h00, ctrl_p = 8'h00, status_p;
    logic       tx, tx_p;

    int         n_vec = 0;
    int         n_err = 0;
    logic [63:0] rx;
    int         rx_n;
    int         unstable;

    always #5 clk = ~clk;

    port_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .port_data_i(data), .port_ctrl_i(ctrl),
        .port_status_o(status), .tx_o(tx)
    );

    port_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .port_data_i(data_p), .port_ctrl_i(ctrl_p),
        .port_status_o(status_p), .tx_o(tx_p)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Records one value per bit period and counts any mid-period change of the line.
    task automatic capture(input bit par, input int nsym);
        logic v;
        for (int s = 0; s < nsym; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick(1);
                v = par ? tx_p : tx;
                if (c == 0) rx[rx_n] = v;
                else if (v !== rx[rx_n]) unstable++;
            end
            rx_n++;
        end
    endtask

    task automatic send(input bit par, input logic [7:0] d);
        if (par) begin
            data_p    = d;
            ctrl_p[0] = ~ctrl_p[0];
        end else begin
            data    = d;
            ctrl[0] = ~ctrl[0];
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ctrl   = 8'h00;
        ctrl_p = 8'h00;
        data   = 8'h00;
        data_p = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        rx       = '0;
        rx_n     = 0;
        unstable = 0;
    endtask

    task automatic test_reset();
        ctrl  = 8'h00;
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_vec++; if (status !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h want 00", status); end
        n_vec++; if (status_p !== 8'h00) begin n_err++; $display("FAIL reset_status_p: got %h want 00", status_p); end
        tick(3);
        rst_n = 1'b1;
        tick(3);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_rel_tx: got %b want 1", tx); end
        n_vec++; if (status !== 8'h00) begin n_err++; $display("FAIL reset_rel_status: got %h want 00", status); end
    endtask

    task automatic test_single_byte();
        do_reset();
        send(0, 8'hA5);
        capture(0, 1);
        n_vec++; if (status !== 8'h01) begin n_err++; $display("FAIL single_busy: got %h want 01", status); end
        capture(0, 9);
        n_vec++; if (rx[9:0] !== {1'b1, 8'hA5, 1'b0}) begin
            n_err++; $display("FAIL single_frame: got %b want %b", rx[9:0], {1'b1, 8'hA5, 1'b0});
        end
        n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL single_timing: got %0d glitches want 0", unstable); end
        n_vec++; if (status !== 8'h01) begin n_err++; $display("FAIL single_last_stop: got %h want 01", status); end
        tick(1);
        n_vec++; if (status !== 8'h18) begin n_err++; $display("FAIL single_done: got %h want 18", status); end
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL single_idle_tx: got %b want 1", tx); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(0, 8'h3C);
        capture(0, 2);
        send(0, 8'h5A);
        capture(0, 1);
        n_vec++; if (status !== 8'h03) begin n_err++; $display("FAIL b2b_hold: got %h want 03", status); end
        capture(0, 17);
        n_vec++; if (rx[9:0] !== {1'b1, 8'h3C, 1'b0}) begin
            n_err++; $display("FAIL b2b_frame1: got %b want %b", rx[9:0], {1'b1, 8'h3C, 1'b0});
        end
        n_vec++; if (rx[19:10] !== {1'b1, 8'h5A, 1'b0}) begin
            n_err++; $display("FAIL b2b_frame2: got %b want %b", rx[19:10], {1'b1, 8'h5A, 1'b0});
        end
        n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL b2b_timing: got %0d glitches want 0", unstable); end
        n_vec++; if (status !== 8'h19) begin n_err++; $display("FAIL b2b_mid: got %h want 19", status); end
        tick(1);
        n_vec++; if (status !== 8'h20) begin n_err++; $display("FAIL b2b_end: got %h want 20", status); end
    endtask

    task automatic test_overrun();
        int lows;
        do_reset();
        send(0, 8'h11);
        capture(0, 1);
        send(0, 8'h22);
        capture(0, 1);
        send(0, 8'h33);
        capture(0, 1);
        n_vec++; if (status !== 8'h07) begin n_err++; $display("FAIL ovr_set: got %h want 07", status); end
        ctrl[7] = 1'b1;
        capture(0, 1);
        ctrl[7] = 1'b0;
        n_vec++; if (status !== 8'h03) begin n_err++; $display("FAIL ovr_clear: got %h want 03", status); end
        capture(0, 16);
        n_vec++; if (rx[19:0] !== {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}) begin
            n_err++; $display("FAIL ovr_frames: got %b want %b", rx[19:0],
                              {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0});
        end
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
        n_vec++; if (lows !== 0) begin n_err++; $display("FAIL ovr_no_third: got %0d low cycles want 0", lows); end
        n_vec++; if (status !== 8'h20) begin n_err++; $display("FAIL ovr_end: got %h want 20", status); end
    endtask

    task automatic test_parity_stop();
        do_reset();
        send(1, 8'h07);
        capture(1, 12);
        n_vec++; if (rx[11:0] !== {2'b11, 1'b1, 8'h07, 1'b0}) begin
            n_err++; $display("FAIL par_frame: got %b want %b", rx[11:0], {2'b11, 1'b1, 8'h07, 1'b0});
        end
        n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL par_timing: got %0d glitches want 0", unstable); end
        n_vec++; if (status_p !== 8'h01) begin n_err++; $display("FAIL par_busy: got %h want 01", status_p); end
        tick(1);
        n_vec++; if (status_p !== 8'h18) begin n_err++; $display("FAIL par_done: got %h want 18", status_p); end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        do_reset();
        send(0, 8'hC3);
        capture(0, 4);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
        n_vec++; if (status !== 8'h00) begin n_err++; $display("FAIL mid_rst_status: got %h want 00", status); end
        tick(3);
        n_vec++; if ({tx, status} !== 9'h100) begin
            n_err++; $display("FAIL mid_rst_hold: got %b/%h want 1/00", tx, status);
        end
        data     = 8'h5E;
        rst_n    = 1'b1;
        rx       = '0;
        rx_n     = 0;
        unstable = 0;
        capture(0, 10);
        n_vec++; if (rx[9:0] !== {1'b1, 8'h5E, 1'b0}) begin
            n_err++; $display("FAIL mid_new_frame: got %b want %b", rx[9:0], {1'b1, 8'h5E, 1'b0});
        end
        n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL mid_timing: got %0d glitches want 0", unstable); end
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
        n_vec++; if (lows !== 0) begin n_err++; $display("FAIL mid_one_frame: got %0d low cycles want 0", lows); end
        n_vec++; if (status !== 8'h18) begin n_err++; $display("FAIL mid_status: got %h want 18", status); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_parity_stop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
